// File: rtl/seg7_time_display.sv
// Registered BCD-to-7-segment stage for six HEX digits with range check and field/alarm blinking.
// Optional build macro HOUR_LEADING_ZERO_BLANK_EN blanks an in-range leading hour zero.
module seg7_time_display #(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned BLINK_HZ = 2
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [3:0] display_h1_export,
    input  logic [3:0] display_h0_export,
    input  logic [3:0] display_m1_export,
    input  logic [3:0] display_m0_export,
    input  logic [3:0] display_s1_export,
    input  logic [3:0] display_s0_export,
    input  logic       load,
    input  logic [1:0] edit_field,
    input  logic       alarm_active,
    output logic [6:0] hex_h1,
    output logic [6:0] hex_h0,
    output logic [6:0] hex_m1,
    output logic [6:0] hex_m0,
    output logic [6:0] hex_s1,
    output logic [6:0] hex_s0
);

    localparam int unsigned HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Digit index order everywhere: 0=h1, 1=h0, 2=m1, 3=m0, 4=s1, 5=s0
    logic [3:0]    din     [6];
    logic [3:0]    dig_q   [6];
    logic [3:0]    dig_d   [6];
    logic [6:0]    hex_q   [6];
    logic [6:0]    hex_d   [6];
    logic          blank   [6];
    logic          dash    [6];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic [1:0]    edit_q;
    logic          alarm_q;
    logic          restart;
    logic          hr_pair_bad;

    assign din[0] = display_h1_export;
    assign din[1] = display_h0_export;
    assign din[2] = display_m1_export;
    assign din[3] = display_m0_export;
    assign din[4] = display_s1_export;
    assign din[5] = display_s0_export;

    assign hex_h1 = hex_q[0];
    assign hex_h0 = hex_q[1];
    assign hex_m1 = hex_q[2];
    assign hex_m0 = hex_q[3];
    assign hex_s1 = hex_q[4];
    assign hex_s0 = hex_q[5];

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    seg_enc = 7'h40;
            4'd1:    seg_enc = 7'h79;
            4'd2:    seg_enc = 7'h24;
            4'd3:    seg_enc = 7'h30;
            4'd4:    seg_enc = 7'h19;
            4'd5:    seg_enc = 7'h12;
            4'd6:    seg_enc = 7'h02;
            4'd7:    seg_enc = 7'h78;
            4'd8:    seg_enc = 7'h00;
            4'd9:    seg_enc = 7'h10;
            default: seg_enc = SEG_DASH;
        endcase
    endfunction

    function automatic logic [3:0] dig_max(input int unsigned idx);
        if (idx == 0)                  dig_max = 4'd2;
        else if (idx == 2 || idx == 4) dig_max = 4'd5;
        else                           dig_max = 4'd9;
    endfunction

    // Blink counter; a new edit field or a rising alarm restarts it in the visible phase
    always_comb begin
        restart = (edit_field != edit_q) || (alarm_active && !alarm_q);
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_comb begin
        hr_pair_bad = (dig_q[0] == 4'd2) && (dig_q[1] > 4'd3);
        for (int unsigned i = 0; i < 6; i++) begin
            dig_d[i] = load ? din[i] : dig_q[i];
            blank[i] = phase_q && (alarm_q || (edit_q == 2'(i / 2 + 1)));
            dash[i]  = (dig_q[i] > dig_max(i)) || ((i < 2) && hr_pair_bad);
            if (blank[i])
                hex_d[i] = SEG_BLANK;
            else if (dash[i])
                hex_d[i] = SEG_DASH;
            else
                hex_d[i] = seg_enc(dig_q[i]);
        end
`ifdef HOUR_LEADING_ZERO_BLANK_EN
        if (dig_q[0] == 4'd0)
            hex_d[0] = SEG_BLANK;
`endif
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int unsigned i = 0; i < 6; i++) begin
                dig_q[i] <= '0;
                hex_q[i] <= SEG_BLANK;
            end
            cnt_q   <= '0;
            phase_q <= 1'b0;
            edit_q  <= '0;
            alarm_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 6; i++) begin
                dig_q[i] <= dig_d[i];
                hex_q[i] <= hex_d[i];
            end
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            edit_q  <= edit_field;
            alarm_q <= alarm_active;
        end
    end

endmodule
